// File: rtl/ldpc_3gpp_dec_state_seq_pkg.sv
// rtl/ldpc_3gpp_dec_state_seq_pkg.sv - shared decoder types used by the vnode state sequencer
package ldpc_3gpp_dec_state_seq_pkg;

    localparam int cZC_W = 9;

    typedef logic [cZC_W-1:0] hb_zc_t;

    typedef struct packed {
        logic sof;
        logic sop;
        logic eop;
        logic eof;
    } strb_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_seq_e;

endpackage

// File: rtl/ldpc_3gpp_dec_state_seq_if.sv
// rtl/ldpc_3gpp_dec_state_seq_if.sv - control and strobe bundle between sequencer and state memory
interface ldpc_3gpp_dec_state_seq_if #(
    parameter int pROW_W  = 4,
    parameter int pITER_W = 6
);
    import ldpc_3gpp_dec_state_seq_pkg::*;

    logic               istart;
    hb_zc_t             iused_zc;
    logic [pROW_W-1:0]  iused_row;
    logic [pITER_W-1:0] initer;
    logic               istop;

    logic               obusy;
    logic               oread;
    logic               orstart;
    strb_t              orstrb;
    logic               owrite;
    strb_t              owstrb;
    logic [pITER_W-1:0] oiter;
    logic               odone;

    modport master (
        input  istart, iused_zc, iused_row, initer, istop,
        output obusy, oread, orstart, orstrb, owrite, owstrb, oiter, odone
    );

    modport slave (
        output istart, iused_zc, iused_row, initer, istop,
        input  obusy, oread, orstart, orstrb, owrite, owstrb, oiter, odone
    );

endinterface

// File: rtl/ldpc_3gpp_dec_state_seq_codec_strb_delay.sv
// rtl/ldpc_3gpp_dec_state_seq_codec_strb_delay.sv - enable-gated fixed delay line for a valid plus frame strobes
module codec_strb_delay
    import ldpc_3gpp_dec_state_seq_pkg::*;
#(
    parameter int pLAT = 8
) (
    input  logic  clk,
    input  logic  resetn,
    input  logic  clkena,
    input  logic  val,
    input  strb_t strb,
    output logic  dly_val,
    output strb_t dly_strb
);

    logic  val_line  [pLAT];
    strb_t strb_line [pLAT];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < pLAT; i++) begin
                val_line[i]  <= 1'b0;
                strb_line[i] <= '0;
            end
        end else if (clkena) begin
            val_line[0]  <= val;
            strb_line[0] <= strb;
            for (int i = 1; i < pLAT; i++) begin
                val_line[i]  <= val_line[i-1];
                strb_line[i] <= strb_line[i-1];
            end
        end
    end

    assign dly_val  = val_line[pLAT-1];
    assign dly_strb = strb_line[pLAT-1];

endmodule

// File: rtl/ldpc_3gpp_dec_state_seq.sv
// rtl/ldpc_3gpp_dec_state_seq.sv - per-iteration read/write strobe sequencer for the vnode state memory
module ldpc_3gpp_dec_state_seq
    import ldpc_3gpp_dec_state_seq_pkg::*;
#(
    parameter int pROW_W    = 4,
    parameter int pITER_W   = 6,
    parameter int pPIPE_LAT = 8
) (
    input  logic                      iclk,
    input  logic                      ireset,
    input  logic                      iclkena,
    ldpc_3gpp_dec_state_seq_if.master bus
);

    state_seq_e         state, state_nxt;
    hb_zc_t             used_zc, zc_cnt;
    logic [pROW_W-1:0]  used_row, row_cnt;
    logic [pITER_W-1:0] niter_m1, iter;
    logic               stop_flag, accept, read, last_row, last_zc, wval;
    strb_t              rstrb, wstrb;

    assign accept   = (state == IDLE) && bus.istart;
    assign read     = (state == READ);
    assign last_row = (row_cnt == used_row - pROW_W'(1));
    assign last_zc  = (zc_cnt == used_zc - hb_zc_t'(1));

    always_comb begin
        rstrb = '0;
        if (read) begin
            rstrb.sof = (row_cnt == '0) && (zc_cnt == '0);
            rstrb.sop = (row_cnt == '0);
            rstrb.eop = last_row;
            rstrb.eof = last_row && last_zc;
        end
    end

    always_ff @(posedge iclk) begin
        if (!ireset) begin
            state <= IDLE;
        end else if (iclkena) begin
            state <= state_nxt;
        end
    end

    // Next iteration may only start once the delayed eof has left the write port.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.istart) state_nxt = READ;
            READ:    if (rstrb.eof) state_nxt = DRAIN;
            DRAIN:   if (wval && wstrb.eof)
                         state_nxt = (iter == niter_m1 || stop_flag || bus.istop) ? DONE : READ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (!ireset) begin
            used_zc   <= '0;
            used_row  <= '0;
            niter_m1  <= '0;
            zc_cnt    <= '0;
            row_cnt   <= '0;
            iter      <= '0;
            stop_flag <= 1'b0;
        end else if (iclkena) begin
            if (accept) begin
                used_zc   <= bus.iused_zc;
                used_row  <= bus.iused_row;
                niter_m1  <= (bus.initer == '0) ? '0 : bus.initer - pITER_W'(1);
                zc_cnt    <= '0;
                row_cnt   <= '0;
                iter      <= '0;
                stop_flag <= 1'b0;
            end else begin
                if (read) begin
                    if (last_row) begin
                        row_cnt <= '0;
                        zc_cnt  <= last_zc ? '0 : zc_cnt + hb_zc_t'(1);
                    end else begin
                        row_cnt <= row_cnt + pROW_W'(1);
                    end
                end
                if ((state == READ || state == DRAIN) && bus.istop)
                    stop_flag <= 1'b1;
                if (state == DRAIN && state_nxt == READ)
                    iter <= iter + pITER_W'(1);
            end
        end
    end

    codec_strb_delay #(
        .pLAT     (pPIPE_LAT)
    ) u_wr_delay (
        .clk      (iclk),
        .resetn   (ireset),
        .clkena   (iclkena),
        .val      (read),
        .strb     (rstrb),
        .dly_val  (wval),
        .dly_strb (wstrb)
    );

    always_comb begin
        bus.obusy   = (state != IDLE);
        bus.oread   = read;
        bus.orstart = read && rstrb.sof;
        bus.orstrb  = rstrb;
        bus.owrite  = wval;
        bus.owstrb  = wstrb;
        bus.oiter   = iter;
        bus.odone   = (state == DONE);
    end

endmodule

// File: tb/tb_ldpc_3gpp_dec_state_seq.sv
// tb/tb_ldpc_3gpp_dec_state_seq.sv - scoreboard bench with a loop-nest reference model of the strobe streams
module tb_ldpc_3gpp_dec_state_seq;
    import ldpc_3gpp_dec_state_seq_pkg::*;

    localparam int LAT = 8;

    typedef struct packed {
        logic [5:0] it;
        strb_t      s;
    } beat_t;

    logic clk     = 1'b0;
    logic resetn  = 1'b0;
    logic clkena  = 1'b1;
    bit   rand_en = 1'b0;

    int total = 0;
    int bad   = 0;

    beat_t rd_q[$];
    beat_t wr_q[$];
    int    rd_cyc_q[$];
    int    done_exp    = 0;
    int    en_cyc      = 0;
    int    acc_cyc     = 0;
    int    last_rd_eof = 0;
    int    last_wr_eof = 0;
    int    rd_cnt      = 0;
    int    rd_eof_cnt  = 0;

    ldpc_3gpp_dec_state_seq_if #(.pROW_W(4), .pITER_W(6)) bus ();

    ldpc_3gpp_dec_state_seq #(
        .pROW_W    (4),
        .pITER_W   (6),
        .pPIPE_LAT (LAT)
    ) dut (
        .iclk    (clk),
        .ireset  (resetn),
        .iclkena (clkena),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        clkena = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Only cycles whose closing edge is enabled count, so timing is in enabled cycles.
    always @(negedge clk) begin
        beat_t e;
        if (resetn && clkena) begin
            en_cyc++;
            if (bus.istart && !bus.obusy) acc_cyc = en_cyc;
            if (bus.oread) begin
                rd_cnt++;
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    e = rd_q.pop_front();
                    check("rd_strb", bus.orstrb, e.s);
                    check("rd_iter", bus.oiter, e.it);
                    check("rd_start", bus.orstart, e.s.sof);
                    if (e.s.sof)
                        check("rd_gap", en_cyc - ((e.it == 0) ? acc_cyc : last_rd_eof),
                              (e.it == 0) ? 1 : LAT + 1);
                end
                rd_cyc_q.push_back(en_cyc);
                if (bus.orstrb.eof) begin
                    last_rd_eof = en_cyc;
                    rd_eof_cnt++;
                end
            end
            if (bus.owrite) begin
                if (wr_q.size() == 0 || rd_cyc_q.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_strb", bus.owstrb, e.s);
                    check("wr_lat", en_cyc - rd_cyc_q.pop_front(), LAT);
                end
                if (bus.owstrb.eof) last_wr_eof = en_cyc;
            end
            if (bus.odone) begin
                if (done_exp == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    done_exp--;
                    check("done_gap", en_cyc - last_wr_eof, 1);
                end
            end
        end
    end

    task automatic run_job(int zc, int row, int nit, int stop_it, int rst_beat, bit pokes);
        int    iters;
        int    budget;
        beat_t b;
        bit    got;
        bit    poked;
        iters = (nit == 0) ? 1 : nit;
        if (stop_it >= 0 && stop_it + 1 < iters) iters = stop_it + 1;
        for (int it = 0; it < iters; it++)
            for (int z = 0; z < zc; z++)
                for (int r = 0; r < row; r++) begin
                    b.it    = 6'(it);
                    b.s.sof = (r == 0) && (z == 0);
                    b.s.sop = (r == 0);
                    b.s.eop = (r == row - 1);
                    b.s.eof = (r == row - 1) && (z == zc - 1);
                    rd_q.push_back(b);
                    wr_q.push_back(b);
                end
        done_exp++;
        rd_cnt     = 0;
        rd_eof_cnt = 0;
        budget     = iters * (zc * row + LAT + 4) * 4 + 200;

        bus.iused_zc  = 9'(zc);
        bus.iused_row = 4'(row);
        bus.initer    = 6'(nit);
        bus.istart    = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            got = clkena;
            #1;
            if (got) break;
        end
        bus.istart = 1'b0;

        if (pokes) begin
            repeat (3) @(posedge clk);
            #1;
            bus.iused_zc  = 9'd1;
            bus.iused_row = 4'd1;
            bus.initer    = 6'd0;
            bus.istart    = 1'b1;
            @(posedge clk);
            #1;
            bus.istart = 1'b0;
        end

        if (rst_beat >= 0) begin
            for (int i = 0; i < budget && rd_cnt < rst_beat; i++) @(posedge clk);
            #1;
            check("rst_reach", rd_cnt, rst_beat);
            resetn = 1'b0;
            @(posedge clk);
            #1;
            resetn = 1'b1;
            rd_q.delete();
            wr_q.delete();
            rd_cyc_q.delete();
            done_exp = 0;
            check("rst_ctrl", {bus.obusy, bus.oread, bus.orstart, bus.owrite, bus.odone}, 0);
            check("rst_strb", {bus.orstrb, bus.owstrb}, 0);
            check("rst_iter", bus.oiter, 0);
            repeat (12) @(posedge clk);
            #1;
            return;
        end

        if (stop_it >= 0) begin
            for (int i = 0; i < budget && rd_eof_cnt < stop_it + 1; i++) @(posedge clk);
            #1;
            bus.istop = 1'b1;
            for (int i = 0; i < 100; i++) begin
                @(posedge clk);
                got = clkena;
                #1;
                if (got) break;
            end
            bus.istop = 1'b0;
        end

        poked = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            bus.istart = 1'b0;
            if (pokes && bus.odone && !poked) begin
                bus.istart = 1'b1;
                poked      = 1'b1;
            end
            if (done_exp == 0 && !bus.obusy) break;
        end
        bus.istart = 1'b0;
        check("job_done", done_exp, 0);
        check("job_idle", bus.obusy, 0);
        check("job_oiter", bus.oiter, iters - 1);
        check("rd_left", rd_q.size(), 0);
        check("wr_left", wr_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        check("idle_after", bus.obusy, 0);
    endtask

    initial begin
        bus.istart    = 1'b0;
        bus.istop     = 1'b0;
        bus.iused_zc  = '0;
        bus.iused_row = '0;
        bus.initer    = '0;
        resetn        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {bus.obusy, bus.oread, bus.orstart, bus.owrite, bus.odone}, 0);
        check("reset_strb", {bus.orstrb, bus.owstrb}, 0);
        check("reset_iter", bus.oiter, 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        run_job(4, 3, 2, -1, -1, 1'b0);
        run_job(1, 1, 1, -1, -1, 1'b0);
        run_job(384, 5, 3, 0, -1, 1'b0);
        rand_en = 1'b1;
        run_job(8, 2, 2, -1, -1, 1'b0);
        rand_en = 1'b0;
        run_job(4, 3, 2, -1, 5, 1'b0);
        run_job(4, 3, 2, -1, -1, 1'b0);
        run_job(5, 2, 0, -1, -1, 1'b1);

        bus.istop = 1'b1;
        @(posedge clk);
        #1;
        bus.istop = 1'b0;

        for (int k = 0; k < 6; k++) begin
            int zc;
            int row;
            int nit;
            int st;
            zc  = $urandom_range(1, 24);
            row = $urandom_range(1, 15);
            nit = $urandom_range(0, 3);
            st  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, ((nit == 0) ? 1 : nit) - 1) : -1;
            rand_en = 1'($urandom_range(0, 1));
            run_job(zc, row, nit, st, -1, 1'b0);
        end
        rand_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
